// File: rtl/layer_sequencer.sv
// Frame sequencer for a hidden layer: packs streamed activations for the neurons, drives the
// shared sweep counter, then captures and streams out the neuron results one per handshake.
module layer_sequencer #(
  parameter int unsigned NEURON_WIDTH = 783,
  parameter int unsigned NEURON_BITS  = 15,
  parameter int unsigned COUNTER_END  = 785,
  parameter int unsigned NUM_NEURONS  = 32,
  parameter int unsigned RESULT_LAT   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [NEURON_BITS:0] in_data,
  input  logic                        in_last,
  output logic signed [NEURON_BITS:0] data_out [0:NEURON_WIDTH],
  output logic [31:0]                 counter,
  input  logic signed [NEURON_BITS+8:0] neuron_in [0:NUM_NEURONS-1],
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [NEURON_BITS+8:0] out_data,
  output logic                        out_last,
  output logic                        busy,
  output logic                        frame_err
);

  localparam int unsigned WrW  = (NEURON_WIDTH > 0) ? $clog2(NEURON_WIDTH + 1) : 1;
  localparam int unsigned OutW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int unsigned LatW = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;

  localparam logic [WrW-1:0]  LastWr  = WrW'(NEURON_WIDTH);
  localparam logic [OutW-1:0] LastOut = OutW'(NUM_NEURONS - 1);
  localparam logic [LatW-1:0] LastLat = LatW'(RESULT_LAT - 1);
  localparam logic [31:0]     CntEnd  = 32'(COUNTER_END);

  typedef enum logic [1:0] {StLoad, StRun, StWait, StDrain} state_e;

  state_e                        state_q, state_d;
  logic [WrW-1:0]                wr_idx_q;
  logic [OutW-1:0]               out_idx_q;
  logic [LatW-1:0]               lat_q;
  logic [31:0]                   counter_q;
  logic                          frame_err_q;
  logic signed [NEURON_BITS:0]   data_q   [0:NEURON_WIDTH];
  logic signed [NEURON_BITS+8:0] result_q [0:NUM_NEURONS-1];

  logic in_fire, out_fire, frame_end, frame_bad, sweep_done, wait_done, drain_done;

  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign frame_end  = in_fire && ((wr_idx_q == LastWr) || in_last);
  // Only a word that is both the last index and flagged in_last closes a frame cleanly.
  assign frame_bad  = frame_end && !((wr_idx_q == LastWr) && in_last);
  assign sweep_done = (state_q == StRun) && (counter_q == CntEnd);
  assign wait_done  = (state_q == StWait) && (lat_q == LastLat);
  assign drain_done = out_fire && (out_idx_q == LastOut);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad:  if (frame_end)  state_d = StRun;
      StRun:   if (sweep_done) state_d = StWait;
      StWait:  if (wait_done)  state_d = StDrain;
      StDrain: if (drain_done) state_d = StLoad;
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StLoad;
      wr_idx_q    <= '0;
      out_idx_q   <= '0;
      lat_q       <= '0;
      counter_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q <= state_d;

      if (in_fire) begin
        wr_idx_q <= frame_end ? '0 : wr_idx_q + WrW'(1);
      end
      if (frame_bad) begin
        frame_err_q <= 1'b1;
      end

      // Counter holds COUNTER_END through WAIT and DRAIN, and clears on return to LOAD.
      if ((state_q == StRun) && !sweep_done) begin
        counter_q <= counter_q + 32'd1;
      end else if (drain_done) begin
        counter_q <= '0;
      end

      if (state_q == StWait) begin
        lat_q <= wait_done ? '0 : lat_q + LatW'(1);
      end

      if (out_fire) begin
        out_idx_q <= drain_done ? '0 : out_idx_q + OutW'(1);
      end
    end
  end

  // Early in_last zero-fills the tail so neurons never see a stale previous frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i <= NEURON_WIDTH; i++) begin
        data_q[i] <= '0;
      end
    end else if (in_fire) begin
      for (int unsigned i = 0; i <= NEURON_WIDTH; i++) begin
        if (WrW'(i) == wr_idx_q) begin
          data_q[i] <= in_data;
        end else if (in_last && (WrW'(i) > wr_idx_q)) begin
          data_q[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
        result_q[i] <= '0;
      end
    end else if (wait_done) begin
      for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
        result_q[i] <= neuron_in[i];
      end
    end
  end

  assign data_out  = data_q;
  assign in_ready  = !rst && (state_q == StLoad);
  assign counter   = rst ? 32'd0 : counter_q;
  assign out_valid = !rst && (state_q == StDrain);
  assign out_data  = out_valid ? result_q[out_idx_q] : '0;
  assign out_last  = out_valid && (out_idx_q == LastOut);
  assign busy      = !rst && (state_q != StLoad);
  assign frame_err = !rst && frame_err_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: a timeline model of the frame (load, sweep, drain) is
// compared against the DUT every cycle, plus literal expectations from hand-worked frames.
module tb_layer_sequencer;

  localparam int NW  = 3;
  localparam int NB  = 15;
  localparam int CE  = 5;
  localparam int NN  = 2;
  localparam int LAT = 1;

  localparam int PhLoad  = 0;
  localparam int PhSweep = 1;
  localparam int PhDrain = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b1;
  logic signed [NB:0] in_data = '0;
  logic in_ready, out_valid, out_last, busy, frame_err;
  logic signed [NB:0]   data_out [0:NW];
  logic [31:0]          counter;
  logic signed [NB+8:0] neuron_in [0:NN-1];
  logic signed [NB+8:0] out_data;

  layer_sequencer #(
    .NEURON_WIDTH(NW),
    .NEURON_BITS (NB),
    .COUNTER_END (CE),
    .NUM_NEURONS (NN),
    .RESULT_LAT  (LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .data_out (data_out),
    .counter  (counter),
    .neuron_in(neuron_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Frame model: phase, words loaded, cycles since the final-input edge, results drained.
  int m_phase, m_idx, m_t, m_oidx;
  bit m_err;
  logic signed [NB:0]   m_buf [0:NW];
  logic signed [NB+8:0] m_res [0:NN-1];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  task model_step();
    if (rst) begin
      m_phase = PhLoad;
      m_idx = 0;
      m_t = 0;
      m_oidx = 0;
      m_err = 1'b0;
      for (int i = 0; i <= NW; i++) m_buf[i] = '0;
      for (int i = 0; i < NN; i++) m_res[i] = '0;
    end else begin
      case (m_phase)
        PhLoad: if (in_valid) begin
          m_buf[m_idx] = in_data;
          if (m_idx == NW || in_last) begin
            for (int i = m_idx + 1; i <= NW; i++) m_buf[i] = '0;
            if (!(m_idx == NW && in_last)) m_err = 1'b1;
            m_idx = 0;
            m_t = 1;
            m_phase = PhSweep;
          end else begin
            m_idx++;
          end
        end
        PhSweep: begin
          m_t++;
          if (m_t == CE + LAT + 2) begin
            for (int i = 0; i < NN; i++) m_res[i] = neuron_in[i];
            m_oidx = 0;
            m_phase = PhDrain;
          end
        end
        default: if (out_ready) begin
          if (m_oidx == NN - 1) m_phase = PhLoad;
          else m_oidx++;
        end
      endcase
    end
  endtask

  task automatic compare();
    longint e_ctr, e_od;
    bit e_ov;
    e_ov  = !rst && m_phase == PhDrain;
    e_ctr = 0;
    if (!rst && m_phase == PhSweep) e_ctr = (m_t - 1 < CE) ? m_t - 1 : CE;
    if (!rst && m_phase == PhDrain) e_ctr = CE;
    e_od = e_ov ? longint'(m_res[m_oidx]) : 0;
    chk("in_ready", in_ready, !rst && m_phase == PhLoad);
    chk("counter", counter, e_ctr);
    chk("out_valid", out_valid, e_ov);
    chk("out_data", out_data, e_od);
    chk("out_last", out_last, e_ov && m_oidx == NN - 1);
    chk("busy", busy, !rst && m_phase != PhLoad);
    chk("frame_err", frame_err, !rst && m_err);
    if (!rst) begin
      for (int i = 0; i <= NW; i++) chk($sformatf("data_out[%0d]", i), data_out[i], m_buf[i]);
    end
  endtask

  always @(posedge clk) model_step();
  always @(negedge clk) if (mon_en) compare();

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [NB:0] d, input bit last);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data = d;
    in_last = last;
    for (int n = 0; n < 300 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_phase(input int ph);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < 200 && !hit; n++) begin
      if (m_phase == ph) hit = 1'b1;
      else tick();
    end
    if (!hit) chk("phase_timeout", 0, 1);
  endtask

  task automatic set_neurons(input int a, input int b);
    neuron_in[0] = (NB + 9)'(a);
    neuron_in[1] = (NB + 9)'(b);
  endtask

  longint ctr_s [1:12];
  longint od_s  [1:12];
  bit     ov_s  [1:12];
  bit     ol_s  [1:12];
  bit     ir_s  [1:12];
  int     first_ov;

  initial begin
    set_neurons(0, 0);
    tick();
    mon_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_counter", counter, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_data_out0", data_out[0], 0);
    tick();

    // Clean frame with hand-worked cycle timeline.
    set_neurons(1234, -567);
    send(10, 0);
    send(-20, 0);
    send(30, 0);
    send(-40, 1);
    first_ov = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      ctr_s[n] = counter;
      ov_s[n] = out_valid;
      od_s[n] = out_data;
      ol_s[n] = out_last;
      ir_s[n] = in_ready;
      if (out_valid && first_ov == 0) first_ov = n;
    end
    chk("t1_first_out_valid_cycle", first_ov, 8);
    chk("t1_counter_c1", ctr_s[1], 0);
    chk("t1_counter_c6", ctr_s[6], 5);
    chk("t1_counter_c7", ctr_s[7], 5);
    chk("t1_out_valid_c7", ov_s[7], 0);
    chk("t1_out_data_c8", od_s[8], 1234);
    chk("t1_out_last_c8", ol_s[8], 0);
    chk("t1_out_data_c9", od_s[9], -567);
    chk("t1_out_last_c9", ol_s[9], 1);
    chk("t1_in_ready_c9", ir_s[9], 0);
    chk("t1_in_ready_c10", ir_s[10], 1);
    chk("t1_data_out0", data_out[0], 10);
    chk("t1_data_out1", data_out[1], -20);
    chk("t1_data_out2", data_out[2], 30);
    chk("t1_data_out3", data_out[3], -40);
    chk("t1_frame_err", frame_err, 0);
    tick();

    // Gapped input; sweep starts right after the 4th acceptance.
    set_neurons(100, 200);
    for (int w = 1; w <= 4; w++) begin
      send(16'(w), w == 4);
      if (w != 4) tick();
    end
    @(negedge clk);
    chk("t2_busy_c1", busy, 1);
    chk("t2_counter_c1", counter, 0);
    chk("t2_data_out2", data_out[2], 3);
    tick();
    wait_phase(PhLoad);

    // Drain stalled for three cycles.
    set_neurons(-1, 7);
    send(11, 0);
    send(12, 0);
    send(13, 0);
    send(14, 1);
    wait_phase(PhDrain);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5_stall_out_data", out_data, -1);
      chk("t5_stall_out_last", out_last, 0);
      chk("t5_stall_in_ready", in_ready, 0);
      chk("t5_stall_counter", counter, CE);
      tick();
    end
    out_ready = 1'b1;
    wait_phase(PhLoad);

    // Reset mid-sweep at counter==3.
    set_neurons(55, 66);
    send(21, 0);
    send(22, 0);
    send(23, 0);
    send(24, 1);
    for (int n = 0; n < 50 && !(m_phase == PhSweep && m_t == 4); n++) tick();
    @(negedge clk);
    chk("t6_counter_before_rst", counter, 3);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("t6_in_ready_in_rst", in_ready, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_counter_after_rst", counter, 0);
    chk("t6_in_ready_after_rst", in_ready, 1);
    chk("t6_data_out3_after_rst", data_out[3], 0);
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      chk("t6_no_out_valid", out_valid, 0);
    end
    tick();
    send(31, 0);
    send(32, 0);
    send(33, 0);
    send(34, 1);
    wait_phase(PhDrain);
    wait_phase(PhLoad);

    // Early in_last zero-fills the tail and flags an error.
    set_neurons(9, -9);
    send(5, 0);
    send(6, 1);
    @(negedge clk);
    chk("t3_data_out0", data_out[0], 5);
    chk("t3_data_out1", data_out[1], 6);
    chk("t3_data_out2", data_out[2], 0);
    chk("t3_data_out3", data_out[3], 0);
    chk("t3_frame_err", frame_err, 1);
    tick();
    wait_phase(PhLoad);

    // Missing in_last; error stays sticky across a later clean frame.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send(41, 0);
    send(42, 0);
    send(43, 0);
    send(44, 0);
    @(negedge clk);
    chk("t4_frame_err", frame_err, 1);
    tick();
    wait_phase(PhLoad);
    send(51, 0);
    send(52, 0);
    send(53, 0);
    send(54, 1);
    wait_phase(PhLoad);
    @(negedge clk);
    chk("t4_frame_err_sticky", frame_err, 1);
    chk("t4_data_out3", data_out[3], 54);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
